// File: rtl/hv_generator_param.sv
// hv_generator_param: latches a frame of channel feature codes and streams one im/projm hypervector beat per channel with valid/ready
module hv_generator_param #(
  parameter int HV_DIMENSION = 2000,
  parameter int FEATURE_WIDTH = 2,
  parameter int NUM_MODALITY = 3,
  parameter int CH_NUM_0 = 32,
  parameter int CH_NUM_1 = 77,
  parameter int CH_NUM_2 = 105,
  parameter int CH_NUM_3 = 0,
  parameter logic [HV_DIMENSION-1:0] SEED = HV_DIMENSION'({63{32'h9E3779B9}}),
  parameter int IM_RESTART_PER_MOD = 0,
  localparam int TOTAL_CH = CH_NUM_0 + (NUM_MODALITY > 1 ? CH_NUM_1 : 0) +
                            (NUM_MODALITY > 2 ? CH_NUM_2 : 0) + (NUM_MODALITY > 3 ? CH_NUM_3 : 0),
  localparam int MAX01 = CH_NUM_0 > CH_NUM_1 ? CH_NUM_0 : CH_NUM_1,
  localparam int MAX23 = CH_NUM_2 > CH_NUM_3 ? CH_NUM_2 : CH_NUM_3,
  localparam int CH_W = $clog2(MAX01 > MAX23 ? MAX01 : MAX23) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              fin_valid,
  output logic                              fin_ready,
  input  logic [TOTAL_CH*FEATURE_WIDTH-1:0] features,
  input  logic                              seed_load,
  input  logic [HV_DIMENSION-1:0]           seed_in,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic [HV_DIMENSION-1:0]           im,
  output logic [HV_DIMENSION-1:0]           projm,
  output logic [1:0]                        mod_id,
  output logic [CH_W-1:0]                   chan_idx,
  output logic [CH_W-1:0]                   num_channel,
  output logic                              last_in_mod,
  output logic                              last,
  output logic                              busy
);
  localparam int GW = $clog2(TOTAL_CH) + 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [TOTAL_CH*FEATURE_WIDTH-1:0] feat_q, feat_d;
  logic [HV_DIMENSION-1:0] seed_q, seed_d, pos_q, pos_d, neg_q, neg_d, im_q, im_d;
  logic [1:0] mod_q, mod_d;
  logic [CH_W-1:0] chan_q, chan_d;
  logic [GW-1:0] g_q, g_d;
  logic [FEATURE_WIDTH-1:0] code;
  function automatic logic [HV_DIMENSION-1:0] r90(input logic [HV_DIMENSION-1:0] x);
    return (x << 1) ^ (x >> 1);
  endfunction
  assign fin_ready = state_q == IDLE;
  assign dout_valid = state_q == STREAM;
  assign busy = state_q == STREAM;
  assign im = im_q;
  assign mod_id = mod_q;
  assign chan_idx = chan_q;
  assign num_channel = mod_q == 2'd0 ? CH_W'(CH_NUM_0) :
                       mod_q == 2'd1 ? CH_W'(CH_NUM_1) :
                       mod_q == 2'd2 ? CH_W'(CH_NUM_2) : CH_W'(CH_NUM_3);
  assign last_in_mod = chan_q == num_channel - 1'b1;
  assign last = last_in_mod && mod_q == 2'(NUM_MODALITY - 1);
  // g_q is the frame-global channel index, so the feature lookup needs no per-modality offset
  assign code = feat_q[int'(g_q)*FEATURE_WIDTH +: FEATURE_WIDTH];
  assign projm = code == FEATURE_WIDTH'(1) ? pos_q : code == FEATURE_WIDTH'(2) ? neg_q : '0;
  always_comb begin
    state_d = state_q;
    feat_d = feat_q;
    seed_d = seed_q;
    pos_d = pos_q;
    neg_d = neg_q;
    im_d = im_q;
    mod_d = mod_q;
    chan_d = chan_q;
    g_d = g_q;
    if (state_q == IDLE) begin
      seed_d = seed_load ? seed_in : seed_q;
      if (fin_valid) begin
        state_d = STREAM;
        feat_d = features;
        pos_d = seed_q;
        neg_d = r90(seed_q);
        im_d = r90(r90(seed_q));
        mod_d = '0;
        chan_d = '0;
        g_d = '0;
      end
    end else if (dout_ready) begin
      state_d = last ? IDLE : STREAM;
      if (!last) begin
        chan_d = last_in_mod ? '0 : chan_q + 1'b1;
        mod_d = last_in_mod ? mod_q + 2'd1 : mod_q;
        g_d = g_q + 1'b1;
        // IM0 is re-derived from the captured pos rather than stored separately
        im_d = (last_in_mod && IM_RESTART_PER_MOD != 0) ? r90(r90(pos_q)) : r90(im_q);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seed_q <= SEED;
      im_q <= '0;
      mod_q <= '0;
      chan_q <= '0;
      g_q <= '0;
    end else begin
      state_q <= state_d;
      seed_q <= seed_d;
      im_q <= im_d;
      mod_q <= mod_d;
      chan_q <= chan_d;
      g_q <= g_d;
    end
  end
  // frame memory survives reset; only a fin fire outside reset rewrites it
  always_ff @(posedge clk) begin
    if (!rst) begin
      feat_q <= feat_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end
endmodule

// File: tb/tb_hv_generator_param.sv
// tb_hv_generator_param: directed checks of the HV generator, continuous-im and restart-im variants side by side
module tb_hv_generator_param;
  logic clk = 0, rst = 1, fin_valid = 0, seed_load = 0, dout_ready = 0;
  logic [11:0] features = '0;
  logic [7:0] seed_in = '0;
  logic fr_a, dv_a, lim_a, last_a, busy_a, fr_b, dv_b, lim_b, last_b, busy_b;
  logic [7:0] im_a, pj_a, im_b, pj_b;
  logic [1:0] mod_a, mod_b;
  logic [2:0] ch_a, nc_a, ch_b, nc_b;
  int checks = 0, failures = 0;
  logic [7:0] e_im [6] = '{8'h44, 8'hAA, 8'h01, 8'h02, 8'h05, 8'h08};
  logic [7:0] e_imr [6] = '{8'h44, 8'hAA, 8'h44, 8'hAA, 8'h01, 8'h44};
  logic [7:0] e_pj [6] = '{8'h10, 8'h28, 8'h00, 8'h00, 8'h10, 8'h28};
  logic [1:0] e_mod [6] = '{0, 0, 1, 1, 1, 2};
  logic [2:0] e_ch [6] = '{0, 1, 0, 1, 2, 0};
  logic [2:0] e_nc [6] = '{2, 2, 3, 3, 3, 1};
  logic e_lim [6] = '{0, 1, 0, 0, 1, 1};
  logic e_last [6] = '{0, 0, 0, 0, 0, 1};
  hv_generator_param #(.HV_DIMENSION(8), .FEATURE_WIDTH(2), .NUM_MODALITY(3), .CH_NUM_0(2), .CH_NUM_1(3),
    .CH_NUM_2(1), .CH_NUM_3(0), .SEED(8'h10), .IM_RESTART_PER_MOD(0)) dut_a (
    .clk(clk), .rst(rst), .fin_valid(fin_valid), .fin_ready(fr_a), .features(features),
    .seed_load(seed_load), .seed_in(seed_in), .dout_valid(dv_a), .dout_ready(dout_ready),
    .im(im_a), .projm(pj_a), .mod_id(mod_a), .chan_idx(ch_a), .num_channel(nc_a),
    .last_in_mod(lim_a), .last(last_a), .busy(busy_a));
  hv_generator_param #(.HV_DIMENSION(8), .FEATURE_WIDTH(2), .NUM_MODALITY(3), .CH_NUM_0(2), .CH_NUM_1(3),
    .CH_NUM_2(1), .CH_NUM_3(0), .SEED(8'h10), .IM_RESTART_PER_MOD(1)) dut_b (
    .clk(clk), .rst(rst), .fin_valid(fin_valid), .fin_ready(fr_b), .features(features),
    .seed_load(seed_load), .seed_in(seed_in), .dout_valid(dv_b), .dout_ready(dout_ready),
    .im(im_b), .projm(pj_b), .mod_id(mod_b), .chan_idx(ch_b), .num_channel(nc_b),
    .last_in_mod(lim_b), .last(last_b), .busy(busy_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_dv"}, {31'd0, dv_a}, 0);
    chk({tag, "_fr"}, {31'd0, fr_a}, 1);
    chk({tag, "_busy"}, {31'd0, busy_a}, 0);
    chk({tag, "_dv_r"}, {31'd0, dv_b}, 0);
  endtask
  task automatic beat_chk(input int i, input bit full, input logic [7:0] pc, input bit use_pc);
    chk($sformatf("dv%0d", i), {31'd0, dv_a}, 1);
    chk($sformatf("busy%0d", i), {31'd0, busy_a}, 1);
    chk($sformatf("fr%0d", i), {31'd0, fr_a}, 0);
    chk($sformatf("mod%0d", i), {30'd0, mod_a}, {30'd0, e_mod[i]});
    chk($sformatf("chan%0d", i), {29'd0, ch_a}, {29'd0, e_ch[i]});
    chk($sformatf("nch%0d", i), {29'd0, nc_a}, {29'd0, e_nc[i]});
    chk($sformatf("lim%0d", i), {31'd0, lim_a}, {31'd0, e_lim[i]});
    chk($sformatf("last%0d", i), {31'd0, last_a}, {31'd0, e_last[i]});
    chk($sformatf("projm%0d", i), {24'd0, pj_a}, {24'd0, use_pc ? pc : e_pj[i]});
    if (full) begin
      chk($sformatf("im%0d", i), {24'd0, im_a}, {24'd0, e_im[i]});
      chk($sformatf("im_rst%0d", i), {24'd0, im_b}, {24'd0, e_imr[i]});
    end
  endtask
  task automatic start(input logic [11:0] f);
    @(negedge clk);
    fin_valid = 1;
    features = f;
    @(negedge clk);
    fin_valid = 0;
  endtask
  task automatic run_frame(input logic [11:0] f, input bit full, input logic [7:0] pc, input bit use_pc,
                           input bit bp, input bit ign);
    start(f);
    if (ign) begin
      fin_valid = 1;
      features = 12'hAAA;
      seed_load = 1;
      seed_in = 8'hFF;
    end
    for (int i = 0; i < 6; i++) begin
      beat_chk(i, full, pc, use_pc);
      if (bp && i == 2) begin
        dout_ready = 0;
        repeat (3) begin
          @(negedge clk);
          beat_chk(i, full, pc, use_pc);
        end
        dout_ready = 1;
      end
      if (i == 5) begin
        fin_valid = 0;
        seed_load = 0;
      end
      @(negedge clk);
    end
    idle_chk("post_frame");
  endtask
  initial begin
    repeat (2) @(negedge clk);
    idle_chk("reset");
    chk("reset_im", {24'd0, im_a}, 0);
    chk("reset_mod", {30'd0, mod_a}, 0);
    chk("reset_chan", {29'd0, ch_a}, 0);
    rst = 0;
    dout_ready = 1;
    run_frame(12'h9C9, 1, 8'h00, 0, 0, 0);
    run_frame(12'h9C9, 1, 8'h00, 0, 1, 0);
    @(negedge clk);
    seed_load = 1;
    seed_in = 8'h01;
    @(negedge clk);
    seed_load = 0;
    start(12'hAAA);
    chk("seed_im0", {24'd0, im_a}, 8'h05);
    for (int i = 0; i < 6; i++) begin
      beat_chk(i, 0, 8'h02, 1);
      @(negedge clk);
    end
    idle_chk("seed_end");
    start(12'h9C9);
    repeat (3) @(negedge clk);
    chk("pre_rst_mod", {30'd0, mod_a}, 1);
    chk("pre_rst_chan", {29'd0, ch_a}, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle_chk("mid_rst");
    chk("mid_rst_im", {24'd0, im_a}, 0);
    repeat (2) @(negedge clk);
    idle_chk("mid_rst_quiet");
    run_frame(12'h9C9, 1, 8'h00, 0, 0, 0);
    run_frame(12'h9C9, 1, 8'h00, 0, 0, 1);
    run_frame(12'hAAA, 1, 8'h28, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
